gpo_ext: RTL and testbench
==========================

GPO_EXT -- requirements
Module: gpo_ext

Interface
REQ-001 SHALL have parameter W, default 8, output port width, legal range 1..32.
REQ-002 SHALL have parameter CW, default 16, width of the blink prescaler and pulse counters.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  slot chip select.
REQ-006 SHALL have port read  input  1  slot read strobe, unused internally, read has no side effects.
REQ-007 SHALL have port write  input  1  slot write strobe.
REQ-008 SHALL have port addr  input  5  register index.
REQ-009 SHALL have port wr_data  input  32  write data.
REQ-010 SHALL have port rd_data  output  32  register readback.
REQ-011 SHALL have port dout  output  W  external output port.

Function
REQ-012 SHALL accept a register write only when cs && write in that cycle; the new state is visible on dout and rd_data in the next cycle.
REQ-013 SHALL use this register map: 0 DATA, 1 SET, 2 CLR, 3 TGL, 4 MODE, 5 PRESC, 6 PLEN, 7 PULSE.
REQ-014 DATA write SHALL give buf <= wr_data[W-1:0]; SET write SHALL give buf |= wr_data; CLR write SHALL give buf &= ~wr_data; TGL write SHALL give buf ^= wr_data (all on bits W-1:0).
REQ-015 MODE write SHALL give mode <= wr_data[W-1:0], where bit=0 is static and bit=1 is blink.
REQ-016 PRESC write SHALL load presc <= wr_data[CW-1:0], clear the prescaler counter to 0, and clear phase to 0.
REQ-017 Prescaler SHALL be free-running: if cnt == presc then cnt <= 0 and phase toggles, else cnt increments; half-period is presc+1 cycles, and presc=0 toggles phase every cycle.
REQ-018 A PRESC write in the same cycle as a terminal count SHALL win: counter is cleared, no toggle.
REQ-019 PLEN write SHALL give plen <= wr_data[CW-1:0].
REQ-020 Pulse FSM SHALL have states IDLE and ACTIVE.
REQ-021 In the pulse FSM, a PULSE write with plen != 0 SHALL load pmask <= wr_data[W-1:0] and pcnt <= plen, and enter ACTIVE.
REQ-022 A PULSE write with plen == 0 SHALL be ignored; state and pmask SHALL be unchanged.
REQ-023 In ACTIVE, pcnt SHALL decrement each cycle, and the FSM SHALL return to IDLE the cycle after pcnt reaches 1; the pulse is active for exactly plen cycles, starting the cycle after the write.
REQ-024 A PULSE write during ACTIVE SHALL retrigger, reloading pmask and pcnt; retrigger SHALL win over decrement and expiry in the same cycle.
REQ-025 Output SHALL be dout[i] = (mode[i] ? buf[i] & phase : buf[i]) | (pmask[i] & active), where active = (state == ACTIVE).
REQ-026 rd_data SHALL be combinational on addr, independent of cs and read, zero-extended to 32 bits:
- DATA, SET, CLR, TGL: buf
- MODE: mode
- PRESC: presc
- PLEN: plen
- PULSE: {busy in bit 0, pmask in bits W:1}
REQ-027 Addresses 8..31 SHALL ignore writes and SHALL read 0.
REQ-028 Write data bits above W-1 (above CW-1 for PRESC and PLEN) SHALL be ignored.

Reset
REQ-029 On reset, buf, mode, pmask, pcnt, cnt and phase SHALL be 0, presc and plen SHALL be 0, and FSM SHALL be IDLE; dout SHALL therefore be 0.
REQ-030 Reset asserted mid-pulse or mid-blink SHALL abort immediately (asynchronously), and dout SHALL go to 0 without waiting for clk.

Structure
REQ-031 Package gpo_pkg SHALL hold the register index constants (REG_DATA..REG_PULSE) and the pulse state enum type (IDLE, ACTIVE).
REQ-032 The prescaler/phase logic SHALL be a sub-module gpo_blink_gen (ports clk, reset, presc, load, phase).
REQ-033 The pulse FSM and register file SHALL remain in gpo_ext.

Verification
REQ-034 W=8: write DATA 0xA5, SET 0x0F, CLR 0x81, TGL 0xFF -> dout 0xA5, 0xAF, 0x2E, 0xD1 on the respective cycles after each write; DATA readback matches each value.
REQ-035 write DATA 0xFF, MODE 0x0F, PRESC 3 -> dout[3:0] alternates 0x0 and 0xF every 4 cycles, starting at 0x0; dout[7:4] stays 0xF.
REQ-036 write PLEN 5, PULSE 0x30 with buf=0 -> dout=0x30 for exactly 5 cycles; PULSE bit 0 reads 1 during the pulse and 0 after.
REQ-037 PLEN 5, PULSE 0x01, then PULSE 0x02 on the 3rd active cycle -> dout 0x01 for 2 cycles, then 0x02 for 5 cycles, then 0x00.
REQ-038 PLEN 0 then PULSE 0xFF -> dout unchanged, busy=0; write to addr 12 -> no state change, and addr 12 reads 0.
REQ-039 assert reset during an active pulse and blink -> dout=0 immediately and all readbacks 0 after release.

Source files
------------

// File: rtl/gpo_pkg.sv
// Shared definitions for the extended general-purpose output block:
// register indices and the pulse FSM state type.
package gpo_pkg;

  localparam logic [4:0] REG_DATA  = 5'd0;
  localparam logic [4:0] REG_SET   = 5'd1;
  localparam logic [4:0] REG_CLR   = 5'd2;
  localparam logic [4:0] REG_TGL   = 5'd3;
  localparam logic [4:0] REG_MODE  = 5'd4;
  localparam logic [4:0] REG_PRESC = 5'd5;
  localparam logic [4:0] REG_PLEN  = 5'd6;
  localparam logic [4:0] REG_PULSE = 5'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/gpo_blink_gen.sv
// Free-running blink prescaler: phase toggles every presc+1 cycles;
// a load restarts the count with phase low.
module gpo_blink_gen #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] presc,
  input  logic          load,
  output logic          phase
);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, whatever order the simulator runs the processes in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      // A reload beats a coincident terminal count: no toggle that cycle.
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == presc) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpo_ext.sv
// Extended GPO slot: buffered output port with per-bit blink mode and a
// retriggerable timed pulse overlay, all behind a small register file.
module gpo_ext
  import gpo_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [W-1:0]  dout
);

  logic [W-1:0]  data_q;
  logic [W-1:0]  mode_q;
  logic [CW-1:0] presc_q;
  logic [CW-1:0] plen_q;
  logic [W-1:0]  pmask_q, pmask_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  pulse_state_e  state_q, state_d;

  logic          wr_en;
  logic          presc_wr;
  logic          pulse_wr;
  logic          phase;
  logic          active;
  logic [W-1:0]  wd;

  assign wr_en    = cs && write;
  assign presc_wr = wr_en && (addr == REG_PRESC);
  assign pulse_wr = wr_en && (addr == REG_PULSE);
  assign wd       = wr_data[W-1:0];
  assign active   = (state_q == ACTIVE);

  // Reads are side-effect free, so the strobe and surplus data bits are unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, read, wr_data};

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      mode_q  <= '0;
      presc_q <= '0;
      plen_q  <= '0;
    end else if (wr_en) begin
      case (addr)
        REG_DATA:  data_q  <= wd;
        REG_SET:   data_q  <= data_q | wd;
        REG_CLR:   data_q  <= data_q & ~wd;
        REG_TGL:   data_q  <= data_q ^ wd;
        REG_MODE:  mode_q  <= wd;
        REG_PRESC: presc_q <= wr_data[CW-1:0];
        REG_PLEN:  plen_q  <= wr_data[CW-1:0];
        default:   ;
      endcase
    end
  end

  // ------------------------------------------------------------ blink phase
  gpo_blink_gen #(
    .CW (CW)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .presc (presc_q),
    .load  (presc_wr),
    .phase (phase)
  );

  // --------------------------------------------------------------- pulse FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      pmask_q <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      pmask_q <= pmask_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    pmask_d = pmask_q;
    if (pulse_wr && (plen_q != '0)) begin
      // Retrigger wins over the decrement/expiry of a running pulse.
      pmask_d = wd;
      pcnt_d  = plen_q;
      state_d = ACTIVE;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (pcnt_q == CW'(1)) begin
            pcnt_d  = '0;
            state_d = IDLE;
          end else begin
            pcnt_d  = pcnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------ output
  always_comb begin
    dout = (data_q & ~mode_q)
         | (data_q & mode_q & {W{phase}})
         | (pmask_q & {W{active}});
  end

  // --------------------------------------------------------------- readback
  logic [32:0] pulse_rd;
  assign pulse_rd = 33'({pmask_q, active});

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_DATA, REG_SET, REG_CLR, REG_TGL: rd_data = 32'(data_q);
      REG_MODE:  rd_data = 32'(mode_q);
      REG_PRESC: rd_data = 32'(presc_q);
      REG_PLEN:  rd_data = 32'(plen_q);
      REG_PULSE: rd_data = pulse_rd[31:0];
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_gpo_ext.sv
// Bench for gpo_ext: directed literal scenarios plus randomized traffic,
// with a cycle-count based reference model checked every cycle.
module tb_gpo_ext;

  localparam int W  = 8;
  localparam int CW = 16;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        cs      = 1'b0;
  logic        read    = 1'b0;
  logic        write   = 1'b0;
  logic [4:0]  addr    = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [W-1:0] dout;

  int errors = 0;
  int checks = 0;

  gpo_ext #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  // Reference model: blink phase derived from cycles elapsed since the
  // last prescaler load; pulse as a remaining-cycles count.
  int unsigned m_buf, m_mode, m_presc, m_plen, m_pmask, m_rem;
  longint      m_k;

  function automatic int unsigned m_phase();
    return int'((m_k / (longint'(m_presc) + 1)) % 2);
  endfunction

  function automatic logic [31:0] m_dout();
    int unsigned v;
    v = (m_buf & ~m_mode) | ((m_phase() != 0) ? (m_buf & m_mode) : 0);
    if (m_rem > 0) v = v | m_pmask;
    return 32'(v & 32'hFF);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd0, 5'd1, 5'd2, 5'd3: return 32'(m_buf);
      5'd4: return 32'(m_mode);
      5'd5: return 32'(m_presc);
      5'd6: return 32'(m_plen);
      5'd7: return 32'((m_pmask * 2) + ((m_rem > 0) ? 1 : 0));
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_buf = 0; m_mode = 0; m_presc = 0; m_plen = 0;
      m_pmask = 0; m_rem = 0; m_k = 0;
    end else begin
      logic pulsed, loaded;
      pulsed = 1'b0;
      loaded = 1'b0;
      if (cs && write) begin
        case (addr)
          5'd0: m_buf = wr_data & 32'hFF;
          5'd1: m_buf = (m_buf | wr_data) & 32'hFF;
          5'd2: m_buf = m_buf & ~wr_data & 32'hFF;
          5'd3: m_buf = (m_buf ^ wr_data) & 32'hFF;
          5'd4: m_mode = wr_data & 32'hFF;
          5'd5: begin m_presc = wr_data & 32'hFFFF; loaded = 1'b1; end
          5'd6: m_plen = wr_data & 32'hFFFF;
          5'd7: if (m_plen != 0) begin
                  m_pmask = wr_data & 32'hFF;
                  m_rem   = m_plen;
                  pulsed  = 1'b1;
                end
          default: ;
        endcase
      end
      if (!pulsed && m_rem > 0) m_rem = m_rem - 1;
      if (loaded) m_k = 0;
      else        m_k = m_k + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_dout", 32'(dout), m_dout());
      check("model_rd", rd_data, m_rd(addr));
    end
  end

  // Apply one cycle of bus activity; returns just after the sampling edge.
  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d);
    cs      = w;
    write   = w;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    cs    = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    #3;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_rd", rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Set/clear/toggle arithmetic.
    step(1, 5'd0, 32'hFFFF_FFA5); check("data_dout", 32'(dout), 32'hA5); check("data_rd", rd_data, 32'hA5);
    step(1, 5'd1, 32'h0F);        check("set_dout",  32'(dout), 32'hAF); check("set_rd",  rd_data, 32'hAF);
    step(1, 5'd2, 32'h81);        check("clr_dout",  32'(dout), 32'h2E); check("clr_rd",  rd_data, 32'h2E);
    step(1, 5'd3, 32'hFF);        check("tgl_dout",  32'(dout), 32'hD1); check("tgl_rd",  rd_data, 32'hD1);

    // Blink with half-period 4 on the low nibble.
    step(1, 5'd0, 32'hFF);
    step(1, 5'd4, 32'h0F);
    step(1, 5'd5, 32'h3);
    check("blink_0", 32'(dout), 32'hF0);
    for (int i = 1; i < 16; i++) begin
      step(0, 5'd5, 32'h0);
      check("blink", 32'(dout), (((i / 4) % 2) != 0) ? 32'hFF : 32'hF0);
    end

    // Single pulse of 5 cycles.
    step(1, 5'd4, 32'h0);
    step(1, 5'd0, 32'h0);
    step(1, 5'd6, 32'd5);
    step(1, 5'd7, 32'h30);
    for (int i = 0; i < 5; i++) begin
      check("pulse_dout", 32'(dout), 32'h30);
      check("pulse_busy", rd_data, 32'h61);
      step(0, 5'd7, 32'h0);
    end
    check("pulse_end_dout", 32'(dout), 32'h0);
    check("pulse_end_rd", rd_data, 32'h60);

    // Retrigger on the third active cycle.
    step(1, 5'd7, 32'h01); check("rt_a1", 32'(dout), 32'h01);
    step(0, 5'd7, 32'h0);  check("rt_a2", 32'(dout), 32'h01);
    step(1, 5'd7, 32'h02); check("rt_b1", 32'(dout), 32'h02);
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd7, 32'h0);
      check("rt_b", 32'(dout), 32'h02);
    end
    step(0, 5'd7, 32'h0);  check("rt_end", 32'(dout), 32'h0);

    // Zero-length pulse and unmapped address.
    step(1, 5'd6, 32'h0);
    step(1, 5'd7, 32'hFF);
    check("plen0_dout", 32'(dout), 32'h0);
    check("plen0_rd", rd_data, 32'h04);
    step(1, 5'd12, 32'hFFFF_FFFF);
    check("addr12_rd", rd_data, 32'h0);
    check("addr12_dout", 32'(dout), 32'h0);

    // Asynchronous reset mid-pulse and mid-blink.
    step(1, 5'd0, 32'hFF);
    step(1, 5'd4, 32'h0F);
    step(1, 5'd5, 32'h1);
    step(1, 5'd6, 32'd20);
    step(1, 5'd7, 32'h0F);
    step(0, 5'd0, 32'h0);
    step(0, 5'd0, 32'h0);
    check("pre_reset_dout", 32'(dout), 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_dout", 32'(dout), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      step(0, 5'(a), 32'h0);
      check("post_reset_rd", rd_data, 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
      a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      d = $urandom;
      if (a == 5'd5) d = $urandom_range(0, 5) | ($urandom_range(0, 1) << 16);
      if (a == 5'd6) d = $urandom_range(0, 6) | ($urandom_range(0, 1) << 20);
      w = ($urandom_range(0, 2) != 0);
      cs      = ($urandom_range(0, 3) != 0) ? w : 1'b0;
      write   = w;
      read    = ($urandom_range(0, 1) != 0);
      addr    = a;
      wr_data = d;
      @(posedge clk);
      #1;
      if ((n % 400) == 399) begin
        #2;
        reset = 1'b1;
        #1;
        check("rand_async_reset", 32'(dout), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
      end
    end

    cs = 1'b0;
    write = 1'b0;
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
